muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Optional MULDIV_DIVZERO_EN: early-exit divide-by-zero with div_zero flag.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
`ifdef MULDIV_DIVZERO_EN
    output logic             div_zero,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [WIDTH-1:0]     mc_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH:0]       rem_q;
    logic                 is_div_q, neg_q, rneg_q;
`ifdef MULDIV_DIVZERO_EN
    logic                 div_zero_q;
`else
    logic                 dz_q;
    logic [WIDTH-1:0]     raw_q;
`endif

    logic                 a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff, rem_next;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rmd_fix;

    // Signed ops run on magnitudes; signs are reapplied in FIX.
    assign a_neg  = ~op[0] & SrcA[WIDTH-1];
    assign b_neg  = ~op[0] & WriteData[WIDTH-1];
    assign a_abs  = a_neg ? -SrcA : SrcA;
    assign b_abs  = b_neg ? -WriteData : WriteData;
    assign b_zero = (WriteData == '0);

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mc_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc_q low half shifts dividend out, quotient in.
    assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mc_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign rem_next  = div_ge ? div_diff : div_shift;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rmd_fix  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) begin
`ifdef MULDIV_DIVZERO_EN
                state_d = (op[1] && b_zero) ? DONE : RUN;
`else
                state_d = RUN;
`endif
            end
            RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mc_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            div_zero_q <= 1'b0;
`else
            dz_q     <= 1'b0;
            raw_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hi_we) hi_q <= WriteData;
                    if (lo_we) lo_q <= WriteData;
                    if (start) begin
                        cnt_q    <= '0;
                        is_div_q <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        rem_q    <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
                        mc_q     <= op[1] ? b_abs : a_abs;
`ifdef MULDIV_DIVZERO_EN
                        div_zero_q <= op[1] & b_zero;
`else
                        dz_q     <= op[1] & b_zero;
                        raw_q    <= SrcA;
`endif
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div_q) begin
                        rem_q <= rem_next;
                        acc_q <= {acc_q[2*WIDTH-1:WIDTH],
                                  acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= mul_next;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
`ifdef MULDIV_DIVZERO_EN
                        hi_q <= rmd_fix;
                        lo_q <= quo_fix;
`else
                        hi_q <= dz_q ? raw_q : rmd_fix;
                        lo_q <= dz_q ? '1 : quo_fix;
`endif
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;
`ifdef MULDIV_DIVZERO_EN
    assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit.
// Follows MULDIV_DIVZERO_EN to select divide-by-zero expectations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] SrcA = '0;
    logic [31:0] WriteData = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] HI, LO;
    logic        busy, done;
`ifdef MULDIV_DIVZERO_EN
    logic        div_zero;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .SrcA(SrcA), .WriteData(WriteData),
        .hi_we(hi_we), .lo_we(lo_we),
        .HI(HI), .LO(LO), .busy(busy),
`ifdef MULDIV_DIVZERO_EN
        .div_zero(div_zero),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          fails  = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01;
    localparam logic [1:0] DIV  = 2'b10, DIVU  = 2'b11;
    localparam int LAT = 34;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, count negedges to done, then check scoreboard entry.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input int poke);
        int   n;
        logic bz;
        res_t r;
        @(negedge clk);
        start = 1'b1; op = o; SrcA = a; WriteData = b;
        sb.push_back('{hi: eh, lo: el});
        @(posedge clk);
        #1;
        start = 1'b0;
        SrcA = $urandom;
        WriteData = $urandom;
        n  = 0;
        bz = 1'b1;
        while (1) begin
            @(negedge clk);
            n++;
            bz &= busy;
            if (n == poke) begin
                start = 1'b1; op = DIVU;
                SrcA = 32'h0000_ffff; WriteData = 32'hdead_beef;
                hi_we = 1'b1; lo_we = 1'b1;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            if (done || n >= 200) break;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({tag, ":latency"}, 32'(n), 32'(lat));
        chk({tag, ":busy_held"}, {31'b0, bz}, 32'd1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, ":HI"}, HI, r.hi);
            chk({tag, ":LO"}, LO, r.lo);
        end else begin
            chk({tag, ":sb_empty"}, 32'(sb.size()), 32'd1);
        end
        hi_m = eh;
        lo_m = el;
        @(negedge clk);
        chk({tag, ":done_low"}, {31'b0, done}, 32'd0);
        chk({tag, ":busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst:busy", {31'b0, busy}, 32'd0);
        chk("rst:done", {31'b0, done}, 32'd0);
        chk("rst:HI", HI, 32'd0);
        chk("rst:LO", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", MULTU, 32'hffff_ffff, 32'hffff_ffff,
               32'hffff_fffe, 32'h0000_0001, LAT, -1);
        run_op("mult_neg", MULT, 32'hffff_fffd, 32'h0000_0007,
               32'hffff_ffff, 32'hffff_ffeb, LAT, -1);
        run_op("mult_min", MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, LAT, -1);
        run_op("div_neg", DIV, 32'hffff_fff9, 32'h0000_0002,
               32'hffff_ffff, 32'hffff_fffd, LAT, -1);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, LAT, -1);
        run_op("div_wrap", DIV, 32'h8000_0000, 32'hffff_ffff,
               32'h0000_0000, 32'h8000_0000, LAT, -1);
        run_op("multu_poke", MULTU, 32'd6, 32'd7,
               32'd0, 32'd42, LAT, 5);

        @(negedge clk);
        hi_we = 1'b1; WriteData = 32'h0000_1234;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        hi_m = 32'h0000_1234;
        chk("mthi:HI", HI, hi_m);
        chk("mthi:LO", LO, lo_m);
        @(negedge clk);
        lo_we = 1'b1; WriteData = 32'h0000_5678;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        lo_m = 32'h0000_5678;
        chk("mtlo:LO", LO, lo_m);
        chk("mtlo:HI", HI, hi_m);

        @(negedge clk);
        start = 1'b1; op = DIVU; SrcA = 32'd1000; WriteData = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst:busy", {31'b0, busy}, 32'd0);
        chk("midrst:done", {31'b0, done}, 32'd0);
        chk("midrst:HI", HI, 32'd0);
        chk("midrst:LO", LO, 32'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd0, 32'd3, LAT, -1);

`ifdef MULDIV_DIVZERO_EN
        run_op("divz_on", DIVU, 32'd5, 32'd0, hi_m, lo_m, 1, -1);
        chk("divz_on:flag", {31'b0, div_zero}, 32'd1);
        repeat (3) @(negedge clk);
        chk("divz_on:flag_hold", {31'b0, div_zero}, 32'd1);
        run_op("after_divz", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, LAT, -1);
        chk("divz_on:flag_clr", {31'b0, div_zero}, 32'd0);
`else
        run_op("divz_u", DIVU, 32'd5, 32'd0,
               32'd5, 32'hffff_ffff, LAT, -1);
        run_op("divz_s", DIV, 32'hffff_fff8, 32'd0,
               32'hffff_fff8, 32'hffff_ffff, LAT, -1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
